uart_rx: RTL and testbench

- Serial receive front-end for the UART peripheral.
- Sits between the external rx pin and the bus/peripheral logic.
- Synchronises the asynchronous rx line and detects start bits.
- Samples 8N1 frames at mid-bit, checks the stop bit, and presents each byte on a valid/ready handshake with a single holding register.
- Flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync.sv | 35 +++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and receiver state encoding.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int UART_CLKS_PER_BIT = 868;   // 100 MHz / 115200, shared with the transmitter

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Brief    : SYNC_STAGES-deep flop chain for an asynchronous input, resets to 1.
// Revision : 1.0
// ============================================================================
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Reset high so an idle line is never mistaken for a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, one-entry valid/ready output.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_s)
    );

    uart_rx_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx using a frame-level timing model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int SS      = 2;
    localparam int LAT     = SS + CPB / 2 + 9 * CPB + 1;  // start edge to rx_valid
    localparam int OPEN_END = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scheduled events (cycle index = posedge count after which the output shows).
    int         ev_cyc[$];
    bit         ev_ferr[$];
    logic [7:0] ev_byte[$];
    int         bs[$];
    int         be[$];

    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;
    logic       m_ferr;
    logic       m_busy;
    logic       r_prev;
    logic       dlv;
    logic [7:0] dbyte;

    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int vld_cnt  = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            ev_cyc.delete();
            ev_ferr.delete();
            ev_byte.delete();
            bs.delete();
            be.delete();
        end else begin
            dlv    = 1'b0;
            dbyte  = 8'h00;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            for (int i = 0; i < ev_cyc.size(); i++) begin
                if (ev_cyc[i] == cyc) begin
                    if (ev_ferr[i]) m_ferr = 1'b1;
                    else begin
                        dlv   = 1'b1;
                        dbyte = ev_byte[i];
                    end
                end
            end
            if (dlv) begin
                if (!m_valid || r_prev) begin
                    m_data  = dbyte;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && r_prev) begin
                m_valid = 1'b0;
            end
            m_busy = 1'b0;
            for (int i = 0; i < bs.size(); i++) begin
                if (cyc >= bs[i] && cyc < be[i]) m_busy = 1'b1;
            end
            chk("rx_valid",  {31'd0, rx_valid},  {31'd0, m_valid});
            chk("rx_data",   {24'd0, rx_data},   {24'd0, m_data});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
            chk("busy",      {31'd0, busy},      {31'd0, m_busy});
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            if (rx_valid && !m_valid) vld_cnt = vld_cnt;
            if (dlv && m_valid && !m_ovr) vld_cnt++;
        end
        r_prev = rx_ready;
    end

    // Caller is one time unit after a rising edge; ends in the same phase.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int t0;
        t0 = cyc + 1;
        bs.push_back(t0 + SS);
        ev_cyc.push_back(stop_ok ? t0 + LAT : t0 + LAT - 1);
        ev_ferr.push_back(!stop_ok);
        ev_byte.push_back(b);
        be.push_back(stop_ok ? t0 + LAT - 1 : OPEN_END);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic line_high(input int n);
        if (be.size() > 0 && be[be.size()-1] == OPEN_END) be[be.size()-1] = cyc + 1 + SS;
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic glitch(input int n);
        int t0;
        t0 = cyc + 1;
        bs.push_back(t0 + SS);
        be.push_back(t0 + SS + CPB / 2);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int t;
    int f0, o0, v0;

    initial begin
        // Reset state
        #2;
        chk("reset rx_data",   {24'd0, rx_data},   32'h00);
        chk("reset rx_valid",  {31'd0, rx_valid},  32'h0);
        chk("reset frame_err", {31'd0, frame_err}, 32'h0);
        chk("reset overrun",   {31'd0, overrun},   32'h0);
        chk("reset busy",      {31'd0, busy},      32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        line_high(5);

        // 1: single frame, exact latency
        rx_ready = 1'b1;
        t = cyc + 1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cyc(t + 154);
                chk("t1 valid before", {31'd0, rx_valid}, 32'h0);
                @(negedge clk);
                chk("t1 valid at 155", {31'd0, rx_valid}, 32'h1);
                chk("t1 data", {24'd0, rx_data}, 32'hA5);
                @(negedge clk);
                chk("t1 valid after", {31'd0, rx_valid}, 32'h0);
            end
        join
        line_high(10);

        // 2: short glitch rejected
        glitch(4);
        line_high(30);
        chk("t2 busy", {31'd0, busy}, 32'h0);

        // 3: framing error followed by break, then good frame
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        chk("t3 busy in break", {31'd0, busy}, 32'h1);
        chk("t3 one frame_err", ferr_cnt - f0, 32'd1);
        chk("t3 no valid", {31'd0, rx_valid}, 32'h0);
        line_high(10);
        send_frame(8'h81, 1'b1);
        line_high(10);
        chk("t3 data 81", {24'd0, rx_data}, 32'h81);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        line_high(10);
        chk("t4 one overrun", ovr_cnt - o0, 32'd1);
        chk("t4 data held", {24'd0, rx_data}, 32'h11);
        chk("t4 valid held", {31'd0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        chk("t4 valid drained", {31'd0, rx_valid}, 32'h0);
        @(posedge clk);
        #1;

        // 6: back-to-back frames
        rx_ready = 1'b1;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        v0 = vld_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        line_high(10);
        chk("t6 deliveries", vld_cnt - v0, 32'd3);
        chk("t6 no frame_err", ferr_cnt - f0, 32'd0);
        chk("t6 no overrun", ovr_cnt - o0, 32'd0);
        chk("t6 last data", {24'd0, rx_data}, 32'h55);

        // 5: asynchronous reset during data bit 3
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (CPB * 4 + 8) @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                chk("t5 rst rx_data",   {24'd0, rx_data},   32'h00);
                chk("t5 rst rx_valid",  {31'd0, rx_valid},  32'h0);
                chk("t5 rst frame_err", {31'd0, frame_err}, 32'h0);
                chk("t5 rst overrun",   {31'd0, overrun},   32'h0);
                chk("t5 rst busy",      {31'd0, busy},      32'h0);
            end
        join
        reset_n = 1'b1;
        line_high(5);
        send_frame(8'h5A, 1'b1);
        line_high(10);
        chk("t5 resend data", {24'd0, rx_data}, 32'h5A);

        line_high(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
